bus_master_port: RTL and testbench



---
 rtl/bus_master_port_pkg.sv | 25 ++
 rtl/bus_timeout_cnt.sv | 32 +++
 rtl/bus_master_port.sv | 130 +++++++++++++
 tb/tb_bus_master_port.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_master_port_pkg.sv
// Shared system-bus definitions: active-low level names, direction codes,
// transaction state encoding and default bus widths.
package bus_master_port_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    localparam int BUS_ADDR_W = 30;
    localparam int BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ADDR = 2'd2,
        ST_WAIT = 2'd3
    } bus_state_t;

    // Enough bits to hold 0..timeout, never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Slave-ready timeout counter: counts enabled cycles from a clear and flags the
// last allowed cycle. TIMEOUT=0 ties the terminal count off permanently.
module bus_timeout_cnt
    import bus_master_port_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int               CNT_W   = cnt_width(TIMEOUT);
    localparam bit               ENABLED = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TC_VAL  = ENABLED ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] cnt;

    // With the tie-off the counter may wrap freely; tc never asserts.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = ENABLED && (cnt == TC_VAL);

endmodule

// File: rtl/bus_master_port.sv
// Master-side bus access engine: arbitrates for the shared bus, issues one
// address strobe, waits for slave ready (or times out) and reports back.
//
// state | meaning
// IDLE  | bus released, waiting for cpu_req
// REQ   | bus_req_ asserted, waiting for arbiter grant
// ADDR  | one-cycle address strobe
// WAIT  | waiting for slave ready, timeout counter running
module bus_master_port
    import bus_master_port_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    bus_state_t        state, state_nxt;
    logic              req_nxt, as_nxt, rw_nxt, done_nxt, err_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wd_nxt, rd_nxt;
    logic              tmo_tc;

    // Cleared during ADDR so the count starts at zero on WAIT entry.
    bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk   (clk),
        .reset (reset),
        .clear (state == ST_ADDR),
        .en    (state == ST_WAIT),
        .tc    (tmo_tc)
    );

    always_comb begin
        state_nxt = state;
        req_nxt   = bus_req_;
        as_nxt    = DISABLE_;
        rw_nxt    = bus_rw;
        addr_nxt  = bus_addr;
        wd_nxt    = bus_wr_data;
        rd_nxt    = cpu_rd_data;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                req_nxt = DISABLE_;
                if (cpu_req) begin
                    state_nxt = ST_REQ;
                    req_nxt   = ENABLE_;
                    rw_nxt    = cpu_rw;
                    addr_nxt  = cpu_addr;
                    wd_nxt    = cpu_wr_data;
                end
            end
            ST_REQ: begin
                if (bus_grnt_ == ENABLE_) begin
                    state_nxt = ST_ADDR;
                    as_nxt    = ENABLE_;
                end
            end
            ST_ADDR: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Ready on the terminal-count cycle still completes normally.
                if (bus_rdy_ == ENABLE_) begin
                    state_nxt = ST_IDLE;
                    req_nxt   = DISABLE_;
                    done_nxt  = 1'b1;
                    if (bus_rw == READ) begin
                        rd_nxt = bus_rd_data;
                    end
                end else if (tmo_tc) begin
                    state_nxt = ST_IDLE;
                    req_nxt   = DISABLE_;
                    err_nxt   = 1'b1;
                    rd_nxt    = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                req_nxt   = DISABLE_;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            bus_req_    <= DISABLE_;
            bus_as_     <= DISABLE_;
            bus_rw      <= READ;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            cpu_rd_data <= '0;
            cpu_busy    <= 1'b0;
            cpu_done    <= 1'b0;
            cpu_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            bus_req_    <= req_nxt;
            bus_as_     <= as_nxt;
            bus_rw      <= rw_nxt;
            bus_addr    <= addr_nxt;
            bus_wr_data <= wd_nxt;
            cpu_rd_data <= rd_nxt;
            cpu_busy    <= (state_nxt != ST_IDLE);
            cpu_done    <= done_nxt;
            cpu_err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: directed vector table, randomized transactions
// against a timeline model, reset mid-WAIT, and two masters sharing an arbiter.
module tb_bus_master_port;
    import bus_master_port_pkg::*;

    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          cpu_req, cpu_rw, cpu_busy, cpu_done, cpu_err;
    logic [AW-1:0] cpu_addr, bus_addr;
    logic [DW-1:0] cpu_wr_data, cpu_rd_data, bus_wr_data, bus_rd_data;
    logic          bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;

    bus_master_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_rw(cpu_rw),
        .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_),
        .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
    );

    // Two masters on a shared bus with a 4-input arbiter and a small memory slave
    logic          a_req, a_rw, a_busy, a_done, a_err, a_breq, a_gnt, a_as, a_brw;
    logic          b_req, b_rw, b_busy, b_done, b_err, b_breq, b_gnt, b_as, b_brw;
    logic [AW-1:0] a_addr, a_baddr, b_addr, b_baddr;
    logic [DW-1:0] a_wd, a_rd, a_bwd, b_wd, b_rd, b_bwd, s_rd;
    logic          s_rdy_;

    bus_master_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) u_a (
        .clk(clk), .reset(reset), .cpu_req(a_req), .cpu_rw(a_rw),
        .cpu_addr(a_addr), .cpu_wr_data(a_wd), .cpu_rd_data(a_rd),
        .cpu_busy(a_busy), .cpu_done(a_done), .cpu_err(a_err),
        .bus_req_(a_breq), .bus_grnt_(a_gnt), .bus_as_(a_as),
        .bus_rw(a_brw), .bus_addr(a_baddr), .bus_wr_data(a_bwd),
        .bus_rd_data(s_rd), .bus_rdy_(s_rdy_)
    );

    bus_master_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) u_b (
        .clk(clk), .reset(reset), .cpu_req(b_req), .cpu_rw(b_rw),
        .cpu_addr(b_addr), .cpu_wr_data(b_wd), .cpu_rd_data(b_rd),
        .cpu_busy(b_busy), .cpu_done(b_done), .cpu_err(b_err),
        .bus_req_(b_breq), .bus_grnt_(b_gnt), .bus_as_(b_as),
        .bus_rw(b_brw), .bus_addr(b_baddr), .bus_wr_data(b_bwd),
        .bus_rd_data(s_rd), .bus_rdy_(s_rdy_)
    );

    int owner;
    function automatic int arb_next(input int cur, input logic [3:0] rq_n);
        if (cur >= 0 && !rq_n[cur]) return cur;
        for (int i = 0; i < 4; i++) if (!rq_n[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) owner <= -1;
        else       owner <= arb_next(owner, {2'b11, b_breq, a_breq});
    end
    assign a_gnt = (owner == 0) ? 1'b0 : 1'b1;
    assign b_gnt = (owner == 1) ? 1'b0 : 1'b1;

    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (reset) begin
            s_rdy_ <= 1'b1;
            s_rd   <= '0;
        end else begin
            s_rdy_ <= 1'b1;
            if (!a_as) begin
                s_rdy_ <= 1'b0;
                if (a_brw == WRITE) mem[a_baddr[3:0]] <= a_bwd;
                s_rd <= mem[a_baddr[3:0]];
            end else if (!b_as) begin
                s_rdy_ <= 1'b0;
                if (b_brw == WRITE) mem[b_baddr[3:0]] <= b_bwd;
                s_rd <= mem[b_baddr[3:0]];
            end
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    bit arb_on = 1'b0;
    always @(negedge clk) begin
        if (arb_on) chk("as_overlap", 64'(!a_as && !b_as), 64'(0));
    end

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        int            gdly;
        int            rdly;
        logic [DW-1:0] rdata;
        int            exp_end;
        bit            exp_ok;
        logic [DW-1:0] exp_rd;
    } vec_t;

    logic [DW-1:0] model_rd;

    task automatic chk_reset();
        chk("rst_bus_req_", 64'(bus_req_), 64'(1));
        chk("rst_bus_as_", 64'(bus_as_), 64'(1));
        chk("rst_bus_rw", 64'(bus_rw), 64'(1));
        chk("rst_bus_addr", 64'(bus_addr), 64'(0));
        chk("rst_bus_wr_data", 64'(bus_wr_data), 64'(0));
        chk("rst_cpu_rd_data", 64'(cpu_rd_data), 64'(0));
        chk("rst_cpu_busy", 64'(cpu_busy), 64'(0));
        chk("rst_cpu_done", 64'(cpu_done), 64'(0));
        chk("rst_cpu_err", 64'(cpu_err), 64'(0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_req = 1'b0; cpu_rw = 1'($urandom); cpu_addr = AW'($urandom);
            cpu_wr_data = $urandom; bus_grnt_ = 1'($urandom); bus_rdy_ = 1'($urandom);
            bus_rd_data = $urandom;
            @(posedge clk); #1;
            chk("idle_bus_req_", 64'(bus_req_), 64'(1));
            chk("idle_bus_as_", 64'(bus_as_), 64'(1));
            chk("idle_busy", 64'(cpu_busy), 64'(0));
            chk("idle_done", 64'(cpu_done), 64'(0));
            chk("idle_err", 64'(cpu_err), 64'(0));
            chk("idle_rd_data", 64'(cpu_rd_data), 64'(model_rd));
        end
    endtask

    // Cycle k ends at edge Ek; the request is sampled at E0 and the access
    // finishes at E(exp_end). Grant/ready noise is injected where it must be ignored.
    task automatic run_txn(input vec_t v);
        logic [DW-1:0] prev_rd;
        prev_rd = model_rd;
        for (int k = 0; k <= v.exp_end; k++) begin
            if (k == 0) begin
                cpu_req = 1'b1; cpu_rw = v.rw; cpu_addr = v.addr; cpu_wr_data = v.wd;
            end else begin
                cpu_req = 1'($urandom); cpu_rw = 1'($urandom);
                cpu_addr = AW'($urandom); cpu_wr_data = $urandom;
            end
            if (k <= v.gdly)          bus_grnt_ = 1'b1;
            else if (k == v.gdly + 1) bus_grnt_ = 1'b0;
            else                      bus_grnt_ = 1'($urandom);
            if (k == 0)                    bus_rdy_ = 1'b1;
            else if (k <= v.gdly + 2)      bus_rdy_ = 1'($urandom);
            else                           bus_rdy_ = (k == 3 + v.gdly + v.rdly) ? 1'b0 : 1'b1;
            bus_rd_data = (k == 3 + v.gdly + v.rdly) ? v.rdata : DW'($urandom);
            @(posedge clk); #1;
            chk("bus_req_", 64'(bus_req_), 64'(k == v.exp_end));
            chk("bus_as_", 64'(bus_as_), 64'(k != v.gdly + 1));
            chk("cpu_busy", 64'(cpu_busy), 64'(k != v.exp_end));
            chk("cpu_done", 64'(cpu_done), 64'((k == v.exp_end) && v.exp_ok));
            chk("cpu_err", 64'(cpu_err), 64'((k == v.exp_end) && !v.exp_ok));
            chk("bus_rw", 64'(bus_rw), 64'(v.rw));
            chk("bus_addr", 64'(bus_addr), 64'(v.addr));
            chk("bus_wr_data", 64'(bus_wr_data), 64'(v.wd));
            chk("cpu_rd_data", 64'(cpu_rd_data), 64'((k == v.exp_end) ? v.exp_rd : prev_rd));
        end
        cpu_req = 1'b0;
        model_rd = v.exp_rd;
    endtask

    task automatic arb_access(input int m, input logic rw, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wd, input logic [DW-1:0] exp);
        bit fin;
        fin = 1'b0;
        if (m == 0) begin a_req = 1'b1; a_rw = rw; a_addr = addr; a_wd = wd; end
        else        begin b_req = 1'b1; b_rw = rw; b_addr = addr; b_wd = wd; end
        @(posedge clk); #1;
        if (m == 0) a_req = 1'b0; else b_req = 1'b0;
        for (int n = 0; n < 60 && !fin; n++) begin
            @(posedge clk); #1;
            fin = (m == 0) ? (a_done || a_err) : (b_done || b_err);
        end
        if (!fin) begin
            chk("arb_timeout", 64'(0), 64'(1));
        end else begin
            chk("arb_done", 64'((m == 0) ? a_done : b_done), 64'(1));
            chk("arb_busy", 64'((m == 0) ? a_busy : b_busy), 64'(0));
            if (rw == READ) chk("arb_rd_data", 64'((m == 0) ? a_rd : b_rd), 64'(exp));
        end
    endtask

    vec_t tbl [8];

    initial begin
        tbl[0] = '{READ,  30'h0000100, 32'h0,        0, 0, 32'hDEADBEEF, 3, 1'b1, 32'hDEADBEEF};
        tbl[1] = '{WRITE, 30'h3FFFFFFF, 32'h12345678, 5, 0, 32'h55555555, 8, 1'b1, 32'hDEADBEEF};
        tbl[2] = '{READ,  30'h0000200, 32'h0,        0, 9, 32'h11111111, 6, 1'b0, 32'h0};
        tbl[3] = '{READ,  30'h1234567, 32'h0,        0, 3, 32'hA5A5A5A5, 6, 1'b1, 32'hA5A5A5A5};
        tbl[4] = '{WRITE, 30'h0000001, 32'hCAFEF00D, 2, 1, 32'h0,        6, 1'b1, 32'hA5A5A5A5};
        tbl[5] = '{READ,  30'h2AAAAAAA, 32'h0,        1, 5, 32'h77777777, 7, 1'b0, 32'h0};
        tbl[6] = '{READ,  30'h0000000, 32'h0,        0, 0, 32'h0000FFFF, 3, 1'b1, 32'h0000FFFF};
        tbl[7] = '{WRITE, 30'h15555555, 32'h0F0F0F0F, 0, 2, 32'h0,        5, 1'b1, 32'h0000FFFF};

        reset = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
        a_req = 1'b0; a_rw = 1'b0; a_addr = '0; a_wd = '0;
        b_req = 1'b0; b_rw = 1'b0; b_addr = '0; b_wd = '0;
        model_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        reset = 1'b0;

        // Directed table, applied back-to-back
        for (int i = 0; i < 8; i++) run_txn(tbl[i]);
        idle(2);

        // Randomized accesses with random gaps, predicted from the timeline rules
        for (int i = 0; i < 150; i++) begin
            vec_t v;
            v.rw    = 1'($urandom);
            v.addr  = AW'($urandom);
            v.wd    = $urandom;
            v.gdly  = int'($urandom_range(0, 6));
            v.rdly  = int'($urandom_range(0, 6));
            v.rdata = $urandom;
            v.exp_ok  = (v.rdly < TMO);
            v.exp_end = v.exp_ok ? (3 + v.gdly + v.rdly) : (2 + v.gdly + TMO);
            v.exp_rd  = !v.exp_ok ? '0 : (v.rw == READ) ? v.rdata : model_rd;
            run_txn(v);
            idle(int'($urandom_range(0, 2)));
        end

        // Reset during WAIT: no done/err, everything back to reset values
        cpu_req = 1'b1; cpu_rw = READ; cpu_addr = 30'h0000ABC; cpu_wr_data = 32'h0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b0; bus_grnt_ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midwait_busy", 64'(cpu_busy), 64'(1));
        chk("midwait_bus_req_", 64'(bus_req_), 64'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        chk_reset();
        reset = 1'b0; bus_grnt_ = 1'b1;
        model_rd = '0;
        idle(4);

        // Two masters contending through the arbiter
        arb_on = 1'b1;
        fork
            begin
                arb_access(0, WRITE, 30'h2, 32'hAAAA0001, 32'h0);
                arb_access(0, READ,  30'h2, 32'h0,        32'hAAAA0001);
            end
            begin
                arb_access(1, WRITE, 30'h5, 32'hBBBB0002, 32'h0);
                arb_access(1, READ,  30'h5, 32'h0,        32'hBBBB0002);
            end
        join
        repeat (2) @(posedge clk);
        arb_on = 1'b0;
        chk("arb_a_err", 64'(a_err), 64'(0));
        chk("arb_b_err", 64'(b_err), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
